// File: rtl/sram_if_pkg.sv
// Shared state encoding, default widths and command type for the SRAM port initiator.
package sram_if_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read response buffer; occupancy is bounded by the initiator's credit count,
// so it never sees a push while full or a pop while empty.
module sram_rsp_fifo #(
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [DATA_W-1:0]              pop_data,
    output logic                           empty,
    output logic [$clog2(RSP_DEPTH+1)-1:0] count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array has no reset; the pointers and count define what is valid,
    // and the read port is forced to zero while empty so nothing stale is ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sram_port_initiator.sv
// Burst initiator for a single-port SRAM (s_addr/s_wen/s_wdata/s_rdata) with
// credit-managed read responses. Define SRAM_INIT_STATS_EN to add access counters.
module sram_port_initiator
    import sram_if_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [DATA_W-1:0] s_wdata,
`ifdef SRAM_INIT_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
`endif
    input  logic [DATA_W-1:0] s_rdata
);

    localparam int CRED_W = $clog2(RSP_DEPTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [CRED_W-1:0]  credits;
    logic [RD_LAT:0]    rd_pipe;
    logic               cmd_fire;
    logic               wr_fire;
    logic               rd_issue;
    logic               rsp_pop;
    logic               fifo_empty;
    logic [CRED_W-1:0]  fifo_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    state_nxt = cmd_wr ? WR : RD;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                if (wr_valid && remaining == '0) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                rd_issue = (credits != '0);
                if (rd_issue && remaining == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_pipe == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign rsp_pop  = rsp_valid && rsp_ready;

    // SRAM port and burst bookkeeping; a bubble cycle drops s_wen but holds s_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            s_addr    <= '0;
            s_wen     <= 1'b0;
            s_wdata   <= '0;
        end else begin
            s_wen <= 1'b0;
            if (cmd_fire) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                s_addr    <= addr;
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
                if (wr_fire) begin
                    s_wen   <= 1'b1;
                    s_wdata <= wr_data;
                end
            end
        end
    end

    // rd_pipe[0] marks a read on the SRAM port; rd_pipe[RD_LAT] marks s_rdata valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
            credits <= CRED_W'(RSP_DEPTH);
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_issue};
            credits <= credits + CRED_W'(rsp_pop) - CRED_W'(rd_issue);
        end
    end

    sram_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pipe[RD_LAT]),
        .push_data (s_rdata),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign busy      = (state != IDLE) || (fifo_count != '0);

`ifdef SRAM_INIT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (wr_fire && stat_wr_cnt != 16'hffff) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
            if (rd_issue && stat_rd_cnt != 16'hffff) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_initiator.sv
// Directed bench for sram_port_initiator against a one-cycle-latency SRAM model.
module tb_sram_port_initiator;
    import sram_if_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 4;
    localparam int RD_LAT    = 1;
    localparam int RSP_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_wr = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wen;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
`ifdef SRAM_INIT_STATS_EN
    logic [15:0]       stat_wr_cnt;
    logic [15:0]       stat_rd_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic              mem_init = 1'b1;
    logic [DATA_W-1:0] mem [16];

    logic [ADDR_W-1:0] addr_q [$];
    logic [DATA_W-1:0] data_q [$];
    int                addr_cyc [$];
    int                data_cyc [$];
    logic [ADDR_W-1:0] last_addr;
    int                cyc;

    always #5 clk = ~clk;

    sram_port_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy),
        .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
`ifdef SRAM_INIT_STATS_EN
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
`endif
        .s_rdata(s_rdata)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // Memory contents after the first write burst (7 <- 5, 8 <- 6).
    function automatic logic [DATA_W-1:0] exp_at(input int a);
        if (a == 7) return 32'd5;
        if (a == 8) return 32'd6;
        return init_val(a);
    endfunction

    function automatic cmd_t make_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        cmd_t c;
        c = {wr, a, l};
        return c;
    endfunction

    // SRAM model: registered read, RD_LAT = 1.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (s_wen) begin
            mem[s_addr] <= s_wdata;
        end
        s_rdata <= mem[s_addr];
    end

    task automatic send_cmd(input cmd_t c);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_idle: got %b, expected 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_wr = c.wr; cmd_addr = c.addr; cmd_len = c.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL cmd_ready_in_burst: got %b, expected 0", cmd_ready); end
    endtask

    task automatic sample_cycles(input int max_cycles, input bit until_idle);
        for (int i = 0; i < max_cycles; i++) begin
            if (s_addr !== last_addr) begin
                addr_q.push_back(s_addr); addr_cyc.push_back(cyc); last_addr = s_addr;
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                data_q.push_back(rsp_data); data_cyc.push_back(cyc);
            end
            if (until_idle && busy === 1'b0) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        addr_q.delete(); data_q.delete(); addr_cyc.delete(); data_cyc.delete();
        last_addr = s_addr;
        cyc = 0;
        send_cmd(make_cmd(1'b0, a, l));
        cyc = 1;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_idle: busy got %b, expected 0 (timeout)", name, busy); end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({cmd_ready, wr_ready, rsp_valid, busy, s_wen} !== 5'b0)
            begin fails++; $display("FAIL reset_ctrl: got %b, expected 00000", {cmd_ready, wr_ready, rsp_valid, busy, s_wen}); end
        tests++;
        if (s_addr !== '0 || s_wdata !== '0 || rsp_data !== '0)
            begin fails++; $display("FAIL reset_data: got %h/%h/%h, expected 0/0/0", s_addr, s_wdata, rsp_data); end
        mem_init = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_cmd_ready: got %b, expected 1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_write_burst;
        send_cmd(make_cmd(1'b1, 4'd7, 4'd1));
        wr_valid = 1'b1; wr_data = 32'd5;
        @(negedge clk);
        tests++;
        if ({s_wen, s_addr, s_wdata} !== {1'b1, 4'd7, 32'd5})
            begin fails++; $display("FAIL wr_word0: got wen=%b addr=%0d data=%0h, expected 1/7/5", s_wen, s_addr, s_wdata); end
        wr_data = 32'd6;
        @(negedge clk);
        wr_valid = 1'b0;
        tests++;
        if ({s_wen, s_addr, s_wdata} !== {1'b1, 4'd8, 32'd6})
            begin fails++; $display("FAIL wr_word1: got wen=%b addr=%0d data=%0h, expected 1/8/6", s_wen, s_addr, s_wdata); end
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_cmd_ready_after: got %b, expected 1", cmd_ready); end
        @(negedge clk);
        tests++;
        if (s_wen !== 1'b0 || mem[7] !== 32'd5 || mem[8] !== 32'd6)
            begin fails++; $display("FAIL wr_mem: got wen=%b mem7=%0h mem8=%0h, expected 0/5/6", s_wen, mem[7], mem[8]); end
    endtask

    task automatic test_read_burst;
        rsp_ready = 1'b1;
        start_read(4'd7, 4'd1);
        sample_cycles(60, 1'b1);
        check_idle("rd");
        tests++;
        if (data_q.size() != 2 || addr_q.size() != 2)
            begin fails++; $display("FAIL rd_counts: got %0d words %0d addrs, expected 2/2", data_q.size(), addr_q.size()); end
        else begin
            tests++;
            if (data_q[0] !== 32'd5 || data_q[1] !== 32'd6)
                begin fails++; $display("FAIL rd_data: got %0h,%0h, expected 5,6", data_q[0], data_q[1]); end
            tests++;
            if (addr_q[0] !== 4'd7 || addr_q[1] !== 4'd8)
                begin fails++; $display("FAIL rd_addr: got %0d,%0d, expected 7,8", addr_q[0], addr_q[1]); end
            tests++;
            if (data_cyc[0] - addr_cyc[0] != RD_LAT + 1)
                begin fails++; $display("FAIL rd_latency: got %0d, expected %0d", data_cyc[0] - addr_cyc[0], RD_LAT + 1); end
            tests++;
            if (data_cyc[1] - data_cyc[0] != 1)
                begin fails++; $display("FAIL rd_consecutive: got gap %0d, expected 1", data_cyc[1] - data_cyc[0]); end
        end
    endtask

    task automatic test_addr_wrap;
        logic [ADDR_W-1:0] exp_a [4];
        exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
        rsp_ready = 1'b1;
        start_read(4'd14, 4'd3);
        sample_cycles(80, 1'b1);
        check_idle("wrap");
        tests++;
        if (data_q.size() != 4 || addr_q.size() != 4)
            begin fails++; $display("FAIL wrap_counts: got %0d words %0d addrs, expected 4/4", data_q.size(), addr_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_q[i] !== exp_a[i] || data_q[i] !== init_val(int'(exp_a[i])))
                    begin fails++; $display("FAIL wrap_word%0d: got addr=%0d data=%h, expected %0d/%h", i, addr_q[i], data_q[i], exp_a[i], init_val(int'(exp_a[i]))); end
            end
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        start_read(4'd2, 4'd7);
        sample_cycles(10, 1'b0);
        tests++;
        if (addr_q.size() != RSP_DEPTH || s_addr !== 4'd3)
            begin fails++; $display("FAIL bp_stall: got %0d issues s_addr=%0d, expected %0d/3", addr_q.size(), s_addr, RSP_DEPTH); end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== init_val(2) || busy !== 1'b1)
            begin fails++; $display("FAIL bp_head: got valid=%b data=%h busy=%b, expected 1/%h/1", rsp_valid, rsp_data, busy, init_val(2)); end
        rsp_ready = 1'b1;
        sample_cycles(200, 1'b1);
        check_idle("bp");
        tests++;
        if (data_q.size() != 8 || addr_q.size() != 8)
            begin fails++; $display("FAIL bp_counts: got %0d words %0d addrs, expected 8/8", data_q.size(), addr_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (data_q[i] !== exp_at(i + 2))
                    begin fails++; $display("FAIL bp_word%0d: got %h, expected %h", i, data_q[i], exp_at(i + 2)); end
            end
        end
    endtask

    task automatic test_gapped_write;
        logic [DATA_W-1:0] d;
        send_cmd(make_cmd(1'b1, 4'd10, 4'd2));
        for (int k = 0; k < 5; k++) begin
            d = 32'h11 * 32'(k / 2 + 1);
            wr_valid = (k % 2 == 0); wr_data = d;
            @(negedge clk);
            tests++;
            if (s_wen !== (k % 2 == 0) || s_addr !== 4'(10 + k / 2))
                begin fails++; $display("FAIL gap_step%0d: got wen=%b addr=%0d, expected %b/%0d", k, s_wen, s_addr, (k % 2 == 0), 10 + k / 2); end
        end
        wr_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem[10] !== 32'h11 || mem[11] !== 32'h22 || mem[12] !== 32'h33 || cmd_ready !== 1'b1)
            begin fails++; $display("FAIL gap_mem: got %h %h %h rdy=%b, expected 11 22 33 1", mem[10], mem[11], mem[12], cmd_ready); end
    endtask

    task automatic test_reset_mid_burst;
        send_cmd(make_cmd(1'b1, 4'd0, 4'd5));
        wr_valid = 1'b1; wr_data = 32'h44;
        @(negedge clk);
        wr_data = 32'h55;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({s_wen, wr_ready, cmd_ready, busy, rsp_valid} !== 5'b0 || s_addr !== '0 || s_wdata !== '0)
            begin fails++; $display("FAIL rst_async_wr: got ctrl=%b addr=%0d data=%h, expected 00000/0/0", {s_wen, wr_ready, cmd_ready, busy, rsp_valid}, s_addr, s_wdata); end
        wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL rst_release_wr: got rdy=%b busy=%b, expected 1/0", cmd_ready, busy); end
        @(negedge clk);
        // Reset with read data buffered: it must be dropped and credits restored.
        rsp_ready = 1'b0;
        start_read(4'd10, 4'd1);
        sample_cycles(6, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0)
            begin fails++; $display("FAIL rst_async_rd: got valid=%b data=%h busy=%b, expected 0/0/0", rsp_valid, rsp_data, busy); end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        start_read(4'd11, 4'd0);
        sample_cycles(40, 1'b1);
        check_idle("rst_rd");
        tests++;
        if (data_q.size() != 1 || data_q[0] !== 32'h22)
            begin fails++; $display("FAIL rst_after_read: got %0d words first=%h, expected 1/22", data_q.size(), data_q.size() > 0 ? data_q[0] : 32'h0); end
    endtask

`ifdef SRAM_INIT_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0)
            begin fails++; $display("FAIL stats_reset: got %0d/%0d, expected 0/0", stat_wr_cnt, stat_rd_cnt); end
        @(negedge clk);
        send_cmd(make_cmd(1'b1, 4'd4, 4'd1));
        wr_valid = 1'b1; wr_data = 32'h66;
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        start_read(4'd4, 4'd3);
        sample_cycles(80, 1'b1);
        check_idle("stats");
        tests++;
        if (stat_wr_cnt !== 16'd2 || stat_rd_cnt !== 16'd4)
            begin fails++; $display("FAIL stats_counts: got %0d/%0d, expected 2/4", stat_wr_cnt, stat_rd_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_addr_wrap();
        test_backpressure();
        test_gapped_write();
        test_reset_mid_burst();
`ifdef SRAM_INIT_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
